// File: rtl/cache_ctrl_assoc_if.sv
// Handshake bundle between the memory-stage pipeline, the per-way cache
// arrays, the banked main memory and the cache_ctrl_assoc sequencer.
interface cache_ctrl_assoc_if #(
  parameter int WAYS      = 2,
  parameter int MEM_BANKS = 4,
  parameter int OFS_W     = $clog2(MEM_BANKS)
);
  // pipeline request and array/memory status
  logic             global_rd;
  logic             global_wr;
  logic [WAYS-1:0]  hit;
  logic [WAYS-1:0]  valid;
  logic [WAYS-1:0]  dirty;
  logic             cache_err;
  logic             mem_err;
  logic             mem_stall;
  // array and memory controls, pipeline status
  logic [WAYS-1:0]  way_sel;
  logic             comp;
  logic             cache_write;
  logic [OFS_W-1:0] cache_ofs;
  logic             mem_rd;
  logic             mem_wr;
  logic [OFS_W-1:0] mem_ofs;
  logic             stall;
  logic             done;
  logic             global_hit;
  logic             err;

  // environment side: drives requests and status, observes controls
  modport master (
    output global_rd, global_wr, hit, valid, dirty, cache_err, mem_err, mem_stall,
    input  way_sel, comp, cache_write, cache_ofs, mem_rd, mem_wr, mem_ofs,
           stall, done, global_hit, err
  );

  // controller side
  modport slave (
    input  global_rd, global_wr, hit, valid, dirty, cache_err, mem_err, mem_stall,
    output way_sel, comp, cache_write, cache_ofs, mem_rd, mem_wr, mem_ofs,
           stall, done, global_hit, err
  );
endinterface

// File: rtl/cache_ctrl_assoc.sv
// Write-back, N-way set-associative cache controller. Sequences tag compare,
// victim write-back, a pipelined line fill (issue and return overlap through a
// MEM_LAT-deep valid shift register) and the final access.
module cache_ctrl_assoc #(
  parameter int WAYS      = 2,
  parameter int MEM_BANKS = 4,
  parameter int MEM_LAT   = 2,
  parameter int OFS_W     = $clog2(MEM_BANKS)
) (
  input  logic               clk,
  input  logic               rst,
  cache_ctrl_assoc_if.slave  bus
);
  // victim index width; a one-way cache still needs a 1-bit index
  localparam int VW = (WAYS > 1) ? $clog2(WAYS) : 1;
  // counters must reach MEM_BANKS itself to mark "all issued"
  localparam int CW = OFS_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FINAL, S_DONE} state_t;

  state_t         r_state, w_state_next;
  logic [CW-1:0]  r_issue_cnt, w_issue_cnt_next;
  logic [CW-1:0]  r_ret_cnt, w_ret_cnt_next;
  logic [VW-1:0]  r_victim, w_victim_next;
  logic [VW-1:0]  r_rr_ptr, w_rr_ptr_next;
  logic           r_abort, w_abort_next;
  logic [MEM_LAT-1:0] r_pipe;

  logic [WAYS-1:0] w_hits, w_hit_sel, w_victim_oh;
  logic [VW-1:0]   w_victim_pick;
  logic            w_hit_any, w_fault, w_ret, w_issue, w_flush;

  assign w_hits    = bus.hit & bus.valid;
  assign w_hit_any = |w_hits;
  // isolate the lowest matching way so way_sel stays one-hot
  assign w_hit_sel = w_hits & (~w_hits + WAYS'(1));
  assign w_fault   = bus.cache_err | bus.mem_err;
  assign w_ret     = r_pipe[MEM_LAT-1];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_victim_oh
      assign w_victim_oh[gi] = (r_victim == VW'(gi));
    end
  endgenerate

  // victim choice: lowest-index invalid way, else the round-robin pointer
  always_comb begin
    w_victim_pick = r_rr_ptr;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!bus.valid[i]) w_victim_pick = VW'(i);
    end
  end

  // next-state, counter updates and all controller outputs
  always_comb begin
    w_state_next     = r_state;
    w_issue_cnt_next = r_issue_cnt;
    w_ret_cnt_next   = r_ret_cnt;
    w_victim_next    = r_victim;
    w_rr_ptr_next    = r_rr_ptr;
    w_abort_next     = r_abort;
    w_issue          = 1'b0;
    w_flush          = 1'b0;
    bus.way_sel      = '0;
    bus.comp         = 1'b0;
    bus.cache_write  = 1'b0;
    bus.cache_ofs    = '0;
    bus.mem_rd       = 1'b0;
    bus.mem_wr       = 1'b0;
    bus.mem_ofs      = '0;
    bus.stall        = 1'b0;
    bus.done         = 1'b0;
    bus.global_hit   = 1'b0;
    bus.err          = 1'b0;

    case (r_state)
      S_IDLE: begin
        bus.comp     = 1'b1;
        w_abort_next = 1'b0;
        if (bus.global_rd && bus.global_wr) begin
          // conflicting request: flag it, touch nothing
          bus.err  = 1'b1;
          bus.done = 1'b1;
        end else if (bus.global_rd || bus.global_wr) begin
          bus.way_sel     = '1;
          bus.cache_write = bus.global_wr;
          if (w_hit_any) begin
            bus.global_hit = 1'b1;
            bus.done       = 1'b1;
            bus.way_sel    = w_hit_sel;
          end else begin
            w_victim_next = w_victim_pick;
            w_state_next  = (bus.dirty[w_victim_pick] && bus.valid[w_victim_pick])
                            ? S_WB : S_FILL;
          end
        end
      end
      S_WB: begin
        bus.stall   = 1'b1;
        bus.way_sel = w_victim_oh;
        if (!bus.mem_stall) begin
          bus.mem_wr    = 1'b1;
          bus.mem_ofs   = r_issue_cnt[OFS_W-1:0];
          bus.cache_ofs = r_issue_cnt[OFS_W-1:0];
          if (r_issue_cnt == CW'(MEM_BANKS - 1)) begin
            w_issue_cnt_next = '0;
            w_state_next     = S_FILL;
          end else begin
            w_issue_cnt_next = r_issue_cnt + CW'(1);
          end
        end
      end
      S_FILL: begin
        bus.stall   = 1'b1;
        bus.way_sel = w_victim_oh;
        if (!bus.mem_stall && (r_issue_cnt < CW'(MEM_BANKS))) begin
          w_issue          = 1'b1;
          bus.mem_rd       = 1'b1;
          bus.mem_ofs      = r_issue_cnt[OFS_W-1:0];
          w_issue_cnt_next = r_issue_cnt + CW'(1);
        end
        if (w_ret) begin
          bus.cache_write = 1'b1;
          bus.cache_ofs   = r_ret_cnt[OFS_W-1:0];
          if (r_ret_cnt == CW'(MEM_BANKS - 1)) begin
            w_ret_cnt_next   = '0;
            w_issue_cnt_next = '0;
            w_state_next     = S_FINAL;
          end else begin
            w_ret_cnt_next = r_ret_cnt + CW'(1);
          end
        end
      end
      S_FINAL: begin
        bus.stall       = 1'b1;
        bus.comp        = 1'b1;
        bus.way_sel     = w_victim_oh;
        bus.cache_write = bus.global_wr && !w_fault;
        w_rr_ptr_next   = (r_rr_ptr == VW'(WAYS - 1)) ? '0 : r_rr_ptr + VW'(1);
        w_state_next    = S_DONE;
      end
      S_DONE: begin
        bus.done     = 1'b1;
        bus.err      = r_abort;
        w_abort_next = 1'b0;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase

    // an error during a miss aborts: report next cycle, keep replacement state
    if ((r_state == S_WB || r_state == S_FILL || r_state == S_FINAL) && w_fault) begin
      w_state_next     = S_DONE;
      w_abort_next     = 1'b1;
      w_issue_cnt_next = '0;
      w_ret_cnt_next   = '0;
      w_rr_ptr_next    = r_rr_ptr;
      w_flush          = 1'b1;
    end

    // while held in reset the outputs look like an idle controller with no request
    if (!rst) begin
      bus.way_sel     = '0;
      bus.comp        = 1'b1;
      bus.cache_write = 1'b0;
      bus.cache_ofs   = '0;
      bus.mem_rd      = 1'b0;
      bus.mem_wr      = 1'b0;
      bus.mem_ofs     = '0;
      bus.stall       = 1'b0;
      bus.done        = 1'b0;
      bus.global_hit  = 1'b0;
      bus.err         = 1'b0;
    end
  end

  // state, counters, victim and replacement pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_issue_cnt <= '0;
      r_ret_cnt   <= '0;
      r_victim    <= '0;
      r_rr_ptr    <= '0;
      r_abort     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_issue_cnt <= w_issue_cnt_next;
      r_ret_cnt   <= w_ret_cnt_next;
      r_victim    <= w_victim_next;
      r_rr_ptr    <= w_rr_ptr_next;
      r_abort     <= w_abort_next;
    end
  end

  // in-flight read tracking: an issue emerges as a return MEM_LAT cycles later
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe <= '0;
    end else if (w_flush) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_issue;
      for (int k = 1; k < MEM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end
endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Scoreboard bench for cache_ctrl_assoc (2 ways, 4 banks, latency 2).
// Stimulus pushes the hand-derived output events of each request; a monitor
// pops one entry whenever the controller shows an event and compares it.
module tb_cache_ctrl_assoc;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   T = 0;

  typedef struct {
    int         cyc;
    bit         rd, wr;
    int         mofs;
    bit         cw;
    int         cofs;
    bit         dn, er, gh, st, chk;
    logic [1:0] ws;
    bit         cp;
  } ev_t;
  ev_t q[$];

  cache_ctrl_assoc_if #(.WAYS(2), .MEM_BANKS(4)) bus();

  cache_ctrl_assoc #(.WAYS(2), .MEM_BANKS(4), .MEM_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, act, expv);
    end
  endtask

  task automatic exp_ev(input int c, input bit rd, input bit wr, input int mofs,
                        input bit cw, input int cofs, input bit dn, input bit er,
                        input bit gh, input bit st, input bit chk,
                        input logic [1:0] ws, input bit cp);
    ev_t e;
    e.cyc = c; e.rd = rd; e.wr = wr; e.mofs = mofs; e.cw = cw; e.cofs = cofs;
    e.dn = dn; e.er = er; e.gh = gh; e.st = st; e.chk = chk; e.ws = ws; e.cp = cp;
    q.push_back(e);
  endtask

  // unstalled fill: reads at base+1..base+4, returns at base+3..base+6
  task automatic exp_fill(input int base, input logic [1:0] ws);
    for (int c = 1; c <= 6; c++) begin
      exp_ev(base + c, c <= 4, 1'b0, c - 1, c >= 3, c - 3,
             1'b0, 1'b0, 1'b0, 1'b1, c >= 3, ws, 1'b0);
    end
  endtask

  task automatic exp_done(input int c, input bit er);
    exp_ev(c, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, er, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic start(input bit rd, input bit wr, input logic [1:0] h,
                       input logic [1:0] v, input logic [1:0] d);
    @(posedge clk); #1;
    T = cyc;
    bus.global_rd = rd; bus.global_wr = wr;
    bus.hit = h; bus.valid = v; bus.dirty = d;
  endtask

  task automatic run_to(input int last, input int stall_mask, input int err_at);
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      bus.mem_stall = stall_mask[k];
      bus.mem_err   = (k == err_at);
    end
  endtask

  task automatic drop_req();
    bus.global_rd = 1'b0; bus.global_wr = 1'b0;
    bus.hit = 2'b00; bus.valid = 2'b00; bus.dirty = 2'b00;
    bus.mem_stall = 1'b0; bus.mem_err = 1'b0; bus.cache_err = 1'b0;
  endtask

  task automatic finish_req(input string nm);
    @(posedge clk); #1;
    drop_req();
    check({nm, "_drain"}, q.size(), 0);
    q.delete();
    $display("request %s issued at cycle %0d complete", nm, T);
  endtask

  task automatic check_reset_outs(input string nm);
    check({nm, "_comp"}, int'(bus.comp), 1);
    check({nm, "_outs"}, int'({bus.way_sel, bus.cache_write, bus.mem_rd, bus.mem_wr,
                               bus.stall, bus.done, bus.global_hit, bus.err,
                               bus.cache_ofs, bus.mem_ofs}), 0);
  endtask

  // monitor: every cycle with an output event consumes one scoreboard entry
  always @(negedge clk) begin : mon
    ev_t e;
    bit  bad;
    if (bus.mem_rd || bus.mem_wr || bus.cache_write || bus.done || bus.err) begin
      n_vec++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event cyc=%0d rd=%b wr=%b cw=%b done=%b err=%b",
                 cyc, bus.mem_rd, bus.mem_wr, bus.cache_write, bus.done, bus.err);
      end else begin
        e = q.pop_front();
        bad = (cyc != e.cyc) || (bus.mem_rd !== e.rd) || (bus.mem_wr !== e.wr) ||
              (bus.cache_write !== e.cw) || (bus.done !== e.dn) || (bus.err !== e.er) ||
              (bus.global_hit !== e.gh) || (bus.stall !== e.st);
        if ((e.rd || e.wr) && int'(bus.mem_ofs) != e.mofs) bad = 1'b1;
        if ((e.cw || e.wr) && int'(bus.cache_ofs) != e.cofs) bad = 1'b1;
        if (e.chk && ((bus.way_sel !== e.ws) || (bus.comp !== e.cp))) bad = 1'b1;
        if (bad) begin
          n_bad++;
          $display("FAIL event got cyc=%0d rd=%b wr=%b mofs=%0d cw=%b cofs=%0d done=%b err=%b ghit=%b stall=%b ws=%b comp=%b; required cyc=%0d rd=%b wr=%b mofs=%0d cw=%b cofs=%0d done=%b err=%b ghit=%b stall=%b ws=%b comp=%b",
                   cyc, bus.mem_rd, bus.mem_wr, bus.mem_ofs, bus.cache_write, bus.cache_ofs,
                   bus.done, bus.err, bus.global_hit, bus.stall, bus.way_sel, bus.comp,
                   e.cyc, e.rd, e.wr, e.mofs, e.cw, e.cofs, e.dn, e.er, e.gh, e.st, e.ws, e.cp);
        end else begin
          $display("event cyc=%0d matched", cyc);
        end
      end
    end
  end

  initial begin
    drop_req();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    rst = 1'b1;

    // read hit on way 1
    start(1'b1, 1'b0, 2'b10, 2'b10, 2'b00);
    exp_ev(T, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1);
    run_to(0, 0, 0);
    finish_req("read_hit");

    // clean read miss, way 1 invalid -> victim 1; rr_ptr 0 -> 1
    start(1'b1, 1'b0, 2'b00, 2'b01, 2'b00);
    exp_fill(T, 2'b10);
    exp_done(T + 8, 1'b0);
    run_to(8, 0, 0);
    finish_req("clean_miss");

    // clean miss with mem_stall at T+2,T+3; way 0 invalid -> victim 0; rr_ptr 1 -> 0
    start(1'b1, 1'b0, 2'b00, 2'b10, 2'b00);
    exp_ev(T + 1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    exp_ev(T + 3, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    exp_ev(T + 4, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    exp_ev(T + 5, 1'b1, 1'b0, 2, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0);
    exp_ev(T + 6, 1'b1, 1'b0, 3, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    exp_ev(T + 7, 1'b0, 1'b0, 0, 1'b1, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    exp_ev(T + 8, 1'b0, 1'b0, 0, 1'b1, 3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    exp_done(T + 10, 1'b0);
    run_to(10, 32'b1100, 0);
    finish_req("stalled_fill");

    // dirty write miss, both valid, rr_ptr 0 -> victim 0 written back; rr_ptr -> 1
    start(1'b0, 1'b1, 2'b00, 2'b11, 2'b01);
    exp_ev(T, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 1'b1);
    for (int k = 0; k < 4; k++)
      exp_ev(T + 1 + k, 1'b0, 1'b1, k, 1'b0, k, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0);
    exp_fill(T + 4, 2'b01);
    exp_ev(T + 11, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1);
    exp_done(T + 12, 1'b0);
    run_to(12, 0, 0);
    finish_req("dirty_miss");

    // mem_err at T+3 during fill of victim rr_ptr=1: abort, rr_ptr stays 1
    start(1'b1, 1'b0, 2'b00, 2'b11, 2'b00);
    exp_ev(T + 1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    exp_ev(T + 2, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    exp_ev(T + 3, 1'b1, 1'b0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    exp_done(T + 4, 1'b1);
    run_to(4, 0, 3);
    finish_req("mem_err");

    // rr_ptr still 1 after the abort -> victim 1; rr_ptr -> 0
    start(1'b1, 1'b0, 2'b00, 2'b11, 2'b00);
    exp_fill(T, 2'b10);
    exp_done(T + 8, 1'b0);
    run_to(8, 0, 0);
    finish_req("rr_after_err");

    // reset asserted at T+4 in the middle of a fill
    start(1'b1, 1'b0, 2'b00, 2'b01, 2'b00);
    exp_ev(T + 1, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    exp_ev(T + 2, 1'b1, 1'b0, 1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0);
    exp_ev(T + 3, 1'b1, 1'b0, 2, 1'b1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0);
    run_to(3, 0, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_reset_outs("midfill_reset");
    drop_req();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_comp", int'(bus.comp), 1);
    check("idle_stall", int'(bus.stall), 0);
    check("reset_drain", q.size(), 0);
    q.delete();
    repeat (4) @(posedge clk);

    // rr_ptr cleared by reset -> both valid, victim 0
    start(1'b1, 1'b0, 2'b00, 2'b11, 2'b00);
    exp_fill(T, 2'b01);
    exp_done(T + 8, 1'b0);
    run_to(8, 0, 0);
    finish_req("rr_after_reset");

    // read and write together: error, no array write
    start(1'b1, 1'b1, 2'b00, 2'b11, 2'b00);
    exp_ev(T, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    run_to(0, 0, 0);
    finish_req("rd_wr_conflict");

    repeat (3) @(posedge clk);
    #1;
    check("final_drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
